// File: rtl/ps2_matrix_kbd.sv
// ps2_matrix_kbd: PS/2 scancode events -> emulated keyboard matrix.
// A host-loadable 512-entry map RAM translates {extended, code} into a matrix
// position or a special level output. Matrix keys get a minimum hold time, so
// fast taps stay visible to a slow guest scan.
// Optional build macro: GHOST_EMU_EN enables one-level ghosting in key_hit.
module ps2_matrix_kbd #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int NUM_SPECIAL = 2,
    parameter int TICK_DIV    = 1024,
    parameter int MIN_HOLD    = 4,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int SW  = (NUM_SPECIAL > 1) ? $clog2(NUM_SPECIAL) : 1,
    localparam int PW  = ((RW + CW) > SW) ? (RW + CW) : SW,
    localparam int MDW = 2 + PW
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   key_strobe,
    input  logic                   key_pressed,
    input  logic                   key_extended,
    input  logic [7:0]             key_code,
    input  logic                   map_we,
    input  logic [8:0]             map_addr,
    input  logic [MDW-1:0]         map_data,
    input  logic                   clear_all,
    input  logic [RW-1:0]          row,
    input  logic [COLS-1:0]        col,
    output logic                   key_hit,
    output logic [NUM_SPECIAL-1:0] special
);

    localparam int NK = ROWS * COLS;
    localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic          flush;
    assign flush = reset | clear_all;

    // ------------------------------------------------------------------
    // Map RAM and event pipeline
    // ------------------------------------------------------------------
    logic [MDW-1:0] map_mem [512];
    logic [MDW-1:0] map_rd;
    logic           s1_vld;
    logic           s1_make;

    // Map RAM: host write port plus synchronous read; read sees the old word on a same-address write
    always_ff @(posedge clk_sys) begin
        if (map_we)
            map_mem[map_addr] <= map_data;
        map_rd <= map_mem[{key_extended, key_code}];
    end

    // S0 register: capture the strobe alongside the map read; flush drops anything in flight
    always_ff @(posedge clk_sys) begin
        if (flush) begin
            s1_vld  <= 1'b0;
            s1_make <= 1'b0;
        end else begin
            s1_vld  <= key_strobe;
            s1_make <= key_pressed;
        end
    end

    logic          ent_valid;
    logic          ent_special;
    logic [PW-1:0] ent_payload;
    logic [RW-1:0] ent_row;
    logic [CW-1:0] ent_col;
    logic [SW-1:0] ent_sidx;
    logic          ev_matrix;
    logic          ev_special;

    assign ent_valid   = map_rd[MDW-1];
    assign ent_special = map_rd[MDW-2];
    assign ent_payload = map_rd[PW-1:0];
    assign ent_row     = ent_payload[RW+CW-1:CW];
    assign ent_col     = ent_payload[CW-1:0];
    assign ent_sidx    = ent_payload[SW-1:0];
    assign ev_matrix   = s1_vld & ent_valid & ~ent_special;
    assign ev_special  = s1_vld & ent_valid &  ent_special;

    // ------------------------------------------------------------------
    // Hold tick prescaler
    // ------------------------------------------------------------------
    logic [TW-1:0] pre_cnt;
    logic          tick;

    assign tick = (pre_cnt == '0);

    // Free-running down-counter; terminal count produces the hold tick
    always_ff @(posedge clk_sys) begin
        if (reset)
            pre_cnt <= TW'(TICK_DIV - 1);
        else if (tick)
            pre_cnt <= TW'(TICK_DIV - 1);
        else
            pre_cnt <= pre_cnt - TW'(1);
    end

    // ------------------------------------------------------------------
    // Per-key state, hold counter and release-pending flag
    // ------------------------------------------------------------------
    logic [NK-1:0] st_q, st_n;
    logic [NK-1:0] pend_q, pend_n;
    logic [HW-1:0] cnt_q [NK];
    logic [HW-1:0] cnt_n [NK];
    logic [HW-1:0] cnt_dec [NK];

    // Next-state for every key: tick ageing first, then the S1 event overrides
    always_comb begin
        st_n   = st_q;
        pend_n = pend_q;
        for (int i = 0; i < NK; i++) begin
            cnt_dec[i] = (tick && cnt_q[i] != '0) ? cnt_q[i] - HW'(1) : cnt_q[i];
            cnt_n[i]   = cnt_dec[i];
            if (pend_q[i] && cnt_dec[i] == '0) begin
                st_n[i]   = 1'b0;
                pend_n[i] = 1'b0;
            end
            if (ev_matrix && ent_row == RW'(i / COLS) && ent_col == CW'(i % COLS)) begin
                if (s1_make) begin
                    // make (including typematic repeat and re-make while pending)
                    st_n[i]   = 1'b1;
                    cnt_n[i]  = HW'(MIN_HOLD);
                    pend_n[i] = 1'b0;
                end else if (cnt_dec[i] == '0) begin
                    st_n[i]   = 1'b0;
                    pend_n[i] = 1'b0;
                end else begin
                    pend_n[i] = 1'b1;
                end
            end
        end
    end

    // Key state registers; reset and clear_all force-release everything
    always_ff @(posedge clk_sys) begin
        if (flush) begin
            st_q   <= '0;
            pend_q <= '0;
            for (int i = 0; i < NK; i++)
                cnt_q[i] <= '0;
        end else begin
            st_q   <= st_n;
            pend_q <= pend_n;
            for (int i = 0; i < NK; i++)
                cnt_q[i] <= cnt_n[i];
        end
    end

    // Special level outputs track make/break directly; out-of-range indices match nothing
    always_ff @(posedge clk_sys) begin
        if (flush) begin
            special <= '0;
        end else if (ev_special) begin
            for (int i = 0; i < NUM_SPECIAL; i++)
                if (ent_sidx == SW'(i))
                    special[i] <= s1_make;
        end
    end

    // ------------------------------------------------------------------
    // Matrix scan
    // ------------------------------------------------------------------
    logic [COLS-1:0] row_bits [ROWS];
    logic [COLS-1:0] sel_cols;
    logic [COLS-1:0] seen_cols;

    // Selected row's pressed columns (zero when row is outside the matrix), plus optional ghosts
    always_comb begin
        sel_cols = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_bits[r] = st_q[r*COLS +: COLS];
            if (row == RW'(r))
                sel_cols = row_bits[r];
        end
        seen_cols = sel_cols;
`ifdef GHOST_EMU_EN
        // any row sharing a pressed column with the selected row leaks its columns through
        for (int r = 0; r < ROWS; r++)
            if ((row_bits[r] & sel_cols) != '0)
                seen_cols = seen_cols | row_bits[r];
`endif
    end

    // Registered, active-low key_hit: low when a driven column sees a pressed key
    always_ff @(posedge clk_sys) begin
        if (flush)
            key_hit <= 1'b1;
        else
            key_hit <= ((seen_cols & ~col) == '0);
    end

endmodule

// File: tb/tb_ps2_matrix_kbd.sv
// Directed bench for ps2_matrix_kbd with TICK_DIV=16, MIN_HOLD=4.
module tb_ps2_matrix_kbd;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;
    logic       map_we;
    logic [8:0] map_addr;
    logic [7:0] map_data;
    logic       clear_all;
    logic [2:0] row;
    logic [7:0] col;
    logic       key_hit;
    logic [1:0] special;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_sys = ~clk_sys;

    ps2_matrix_kbd #(
        .ROWS(8), .COLS(8), .NUM_SPECIAL(2), .TICK_DIV(16), .MIN_HOLD(4)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .key_strobe(key_strobe), .key_pressed(key_pressed),
        .key_extended(key_extended), .key_code(key_code),
        .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
        .clear_all(clear_all), .row(row), .col(col),
        .key_hit(key_hit), .special(special)
    );

    typedef struct {
        logic [2:0] r;
        logic [7:0] c;
        logic       exp;
    } scan_vec_t;

    scan_vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic map_wr(input logic [8:0] a, input logic [7:0] d);
        map_we = 1'b1; map_addr = a; map_data = d;
        step(1);
        map_we = 1'b0;
    endtask

    task automatic strobe(input logic ext, input logic [7:0] code, input logic mk);
        key_strobe = 1'b1; key_extended = ext; key_code = code; key_pressed = mk;
        step(1);
        key_strobe = 1'b0;
    endtask

    task automatic clr();
        clear_all = 1'b1;
        step(1);
        clear_all = 1'b0;
    endtask

    int  k;
    logic saw_hi;

    initial begin
        reset = 1'b1; key_strobe = 1'b0; key_pressed = 1'b0; key_extended = 1'b0;
        key_code = 8'h00; map_we = 1'b0; map_addr = 9'h000; map_data = 8'h00;
        clear_all = 1'b0; row = 3'd0; col = 8'hFF;

        vecs[0] = '{3'd6, ~8'h20, 1'b0};
        vecs[1] = '{3'd6, ~8'h01, 1'b1};
        vecs[2] = '{3'd6,  8'h00, 1'b0};
        vecs[3] = '{3'd6,  8'hFF, 1'b1};
        vecs[4] = '{3'd4, ~8'h08, 1'b0};
        vecs[5] = '{3'd4, ~8'h20, 1'b1};
        vecs[6] = '{3'd5,  8'h00, 1'b1};
        vecs[7] = '{3'd6, ~8'h28, 1'b0};
        vecs[8] = '{3'd4, ~8'h28, 1'b0};
        vecs[9] = '{3'd0,  8'h00, 1'b1};

        step(3);
        reset = 1'b0;
        chk("reset_key_hit", 32'(key_hit), 32'd1);
        chk("reset_special", 32'(special), 32'd0);

        // map: {valid, special, row[2:0], col[2:0]}
        map_wr(9'h01C, 8'hB5);   // r6,c5
        map_wr(9'h078, 8'hC0);   // special 0
        map_wr(9'h009, 8'hC1);   // special 1
        map_wr(9'h175, 8'hA3);   // ext -> r4,c3
        map_wr(9'h075, 8'h00);   // unmapped
        map_wr(9'h010, 8'h80);   // r0,c0
        map_wr(9'h011, 8'h81);   // r0,c1
        map_wr(9'h012, 8'h88);   // r1,c0

        // latency: key_hit low exactly at strobe+3
        row = 3'd6; col = ~8'h20;
        strobe(1'b0, 8'h1C, 1'b1);
        chk("lat_s1", 32'(key_hit), 32'd1);
        step(1);
        chk("lat_s2", 32'(key_hit), 32'd1);
        step(1);
        chk("lat_s3", 32'(key_hit), 32'd0);

        // extended vs. non-extended
        row = 3'd4; col = ~8'h08;
        strobe(1'b0, 8'h75, 1'b1);
        step(2);
        chk("nonext_ignored", 32'(key_hit), 32'd1);
        strobe(1'b1, 8'h75, 1'b1);
        step(2);
        chk("ext_pressed", 32'(key_hit), 32'd0);

        // scan table with (6,5) and (4,3) pressed
        for (int i = 0; i < 10; i++) begin
            row = vecs[i].r; col = vecs[i].c;
            step(1);
            chk($sformatf("scan_%0d", i), 32'(key_hit), 32'(vecs[i].exp));
        end

        row = 3'd6; col = ~8'h20;
        step(1);
        clr();
        chk("clear_all_hit", 32'(key_hit), 32'd1);

        // hold: make, break two cycles later, release at the 4th tick
        strobe(1'b0, 8'h1C, 1'b1);
        step(1);
        strobe(1'b0, 8'h1C, 1'b0);
        k = 3;
        while (key_hit == 1'b0 && k < 120) begin
            step(1);
            k++;
        end
        chk("hold_release_not_early", 32'(k >= 52), 32'd1);
        chk("hold_release_not_late", 32'(k <= 67), 32'd1);

        // re-make inside the hold window: no release, hold restarts
        clr();
        saw_hi = 1'b0;
        strobe(1'b0, 8'h1C, 1'b1);
        step(1);
        strobe(1'b0, 8'h1C, 1'b0);
        k = 3;
        while (k < 20) begin
            if (key_hit) saw_hi = 1'b1;
            step(1);
            k++;
        end
        strobe(1'b0, 8'h1C, 1'b1);
        step(1);
        strobe(1'b0, 8'h1C, 1'b0);
        k = 23;
        while (key_hit == 1'b0 && k < 150) begin
            step(1);
            k++;
        end
        chk("remake_no_release", 32'(saw_hi), 32'd0);
        chk("remake_hold_restart", 32'(k >= 72), 32'd1);
        chk("remake_release_late", 32'(k <= 87), 32'd1);

        // specials, back-to-back strobes, no hold stretching
        clr();
        strobe(1'b0, 8'h78, 1'b1);
        chk("spec_s1", 32'(special), 32'd0);
        strobe(1'b0, 8'h09, 1'b1);
        chk("spec_make0", 32'(special), 32'd1);
        step(1);
        chk("spec_make1", 32'(special), 32'd3);
        strobe(1'b0, 8'h78, 1'b0);
        step(1);
        chk("spec_break0", 32'(special), 32'd2);

        // synchronous reset clears special and keys
        strobe(1'b0, 8'h1C, 1'b1);
        step(2);
        chk("pre_reset_hit", 32'(key_hit), 32'd0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_reset_hit", 32'(key_hit), 32'd1);
        chk("mid_reset_special", 32'(special), 32'd0);

        // same-cycle map write: strobe sees the old entry
        map_we = 1'b1; map_addr = 9'h01C; map_data = 8'hB4;   // r6,c4
        key_strobe = 1'b1; key_extended = 1'b0; key_code = 8'h1C; key_pressed = 1'b1;
        step(1);
        map_we = 1'b0; key_strobe = 1'b0;
        step(2);
        chk("wr_same_old_c5", 32'(key_hit), 32'd0);
        col = ~8'h10;
        step(1);
        chk("wr_same_not_c4", 32'(key_hit), 32'd1);
        clr();
        strobe(1'b0, 8'h1C, 1'b1);
        step(2);
        chk("wr_new_c4", 32'(key_hit), 32'd0);
        clr();
        map_wr(9'h01C, 8'hB5);

        // in-flight strobe discarded by clear_all
        col = ~8'h20;
        strobe(1'b0, 8'h1C, 1'b1);
        clr();
        step(3);
        chk("inflight_discard", 32'(key_hit), 32'd1);

        // ghosting
        strobe(1'b0, 8'h10, 1'b1);
        strobe(1'b0, 8'h11, 1'b1);
        strobe(1'b0, 8'h12, 1'b1);
        step(2);
        row = 3'd1; col = ~8'h01;
        step(1);
        chk("ghost_real_key", 32'(key_hit), 32'd0);
        col = ~8'h02;
        step(1);
`ifdef GHOST_EMU_EN
        chk("ghost_phantom", 32'(key_hit), 32'd0);
`else
        chk("ghost_phantom", 32'(key_hit), 32'd1);
`endif
        row = 3'd0;
        step(1);
        chk("ghost_row0_c1", 32'(key_hit), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
